// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// The optional DMEM_BYTE_EN build adds per-byte write enables.
package mips_mem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // Word-index width for a power-of-two depth of at least 2.
  function automatic int dmem_idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus; ByteEn exists only when DMEM_BYTE_EN is defined.
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic [DMEM_WORD_W-1:0] i_MEM_mem_DmemAddr;
  logic [DMEM_WORD_W-1:0] i_MEM_mem_DmemDataW;
  logic                   i_MEM_mem_MemRead;
  logic                   i_MEM_mem_MemWrite;
`ifdef DMEM_BYTE_EN
  logic [DMEM_BYTES-1:0]  i_MEM_mem_ByteEn;
`endif
  logic [DMEM_WORD_W-1:0] o_MEM_mem_DmemDataR;
  logic                   o_MEM_mem_Stall;
  logic                   o_MEM_mem_Fault;

  modport master (
    output i_MEM_mem_DmemAddr, i_MEM_mem_DmemDataW, i_MEM_mem_MemRead, i_MEM_mem_MemWrite,
`ifdef DMEM_BYTE_EN
    output i_MEM_mem_ByteEn,
`endif
    input  o_MEM_mem_DmemDataR, o_MEM_mem_Stall, o_MEM_mem_Fault
  );

  modport slave (
    input  i_MEM_mem_DmemAddr, i_MEM_mem_DmemDataW, i_MEM_mem_MemRead, i_MEM_mem_MemWrite,
`ifdef DMEM_BYTE_EN
    input  i_MEM_mem_ByteEn,
`endif
    output o_MEM_mem_DmemDataR, o_MEM_mem_Stall, o_MEM_mem_Fault
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with byte write mask and a clearable registered read port.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic [IDX_W-1:0]       addr_i,
  input  logic [DMEM_WORD_W-1:0] wdata_i,
  input  logic [DMEM_BYTES-1:0]  wmask_i,
  output logic [DMEM_WORD_W-1:0] rdata_o
);

  logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [DMEM_WORD_W-1:0] rdata_q;

  // Storage is deliberately not reset; only enabled bytes are written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DMEM_BYTES; b++) begin
        if (wmask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register: clear wins, otherwise load on read, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rdata_q <= {DMEM_WORD_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a MEM-stage request, stalls for LATENCY cycles,
// then commits the access on the BUSY->DONE edge. Optional macro: DMEM_BYTE_EN.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int               IDX_W    = dmem_idx_w(DEPTH_WORDS);
  localparam int               CNT_W    = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               FAST     = (LATENCY == 1);

  dmem_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
  logic [DMEM_BYTES-1:0]  ben_q, ben_d;
  logic                   rd_q, rd_d, wr_q, wr_d, flt_q, flt_d;
  logic                   fault_q;

  logic                   req_s, in_fault_s, go_s, stall_s;
  logic [DMEM_BYTES-1:0]  in_ben_s, cur_ben_s;
  logic [IDX_W-1:0]       cur_idx_s;
  logic [DMEM_WORD_W-1:0] cur_wdata_s, rdata_s;
  logic                   cur_rd_s, cur_wr_s, cur_flt_s;
  logic                   we_s, re_s, clr_s;

`ifdef DMEM_BYTE_EN
  assign in_ben_s = bus.i_MEM_mem_ByteEn;
`else
  assign in_ben_s = {DMEM_BYTES{1'b1}};
`endif

  assign req_s      = bus.i_MEM_mem_MemRead | bus.i_MEM_mem_MemWrite;
  assign in_fault_s = (bus.i_MEM_mem_DmemAddr[1:0] != 2'b00)
                    | ({2'b00, bus.i_MEM_mem_DmemAddr[31:2]} >= 32'(DEPTH_WORDS))
                    | (bus.i_MEM_mem_MemRead & bus.i_MEM_mem_MemWrite);

  // In IDLE the live bus is the request (matters only when LATENCY is 1).
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_idx_s   = bus.i_MEM_mem_DmemAddr[IDX_W+1:2];
      cur_wdata_s = bus.i_MEM_mem_DmemDataW;
      cur_ben_s   = in_ben_s;
      cur_rd_s    = bus.i_MEM_mem_MemRead;
      cur_wr_s    = bus.i_MEM_mem_MemWrite;
      cur_flt_s   = in_fault_s;
    end else begin
      cur_idx_s   = idx_q;
      cur_wdata_s = wdata_q;
      cur_ben_s   = ben_q;
      cur_rd_s    = rd_q;
      cur_wr_s    = wr_q;
      cur_flt_s   = flt_q;
    end
  end

  // Access-commit strobe and combinational stall.
  always_comb begin
    go_s    = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        go_s    = FAST && req_s;
        stall_s = req_s;
      end
      ST_BUSY: begin
        go_s    = (cnt_q == CNT_ONE);
        stall_s = 1'b1;
      end
      ST_DONE: begin
        go_s    = 1'b0;
        stall_s = 1'b0;
      end
      default: begin
        go_s    = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  // Reset suppresses a commit that coincides with it; faulted reads clear DataR.
  assign we_s  = go_s & cur_wr_s & ~cur_flt_s & ~rst;
  assign re_s  = go_s & cur_rd_s & ~cur_flt_s & ~rst;
  assign clr_s = rst | (go_s & cur_rd_s & cur_flt_s);

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          idx_d   = bus.i_MEM_mem_DmemAddr[IDX_W+1:2];
          wdata_d = bus.i_MEM_mem_DmemDataW;
          ben_d   = in_ben_s;
          rd_d    = bus.i_MEM_mem_MemRead;
          wr_d    = bus.i_MEM_mem_MemWrite;
          flt_d   = in_fault_s;
          cnt_d   = CNT_LOAD;
          state_d = FAST ? ST_DONE : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      wdata_q <= {DMEM_WORD_W{1'b0}};
      ben_q   <= {DMEM_BYTES{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      fault_q <= go_s & cur_flt_s;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .clr_i   (clr_s),
    .we_i    (we_s),
    .re_i    (re_s),
    .addr_i  (cur_idx_s),
    .wdata_i (cur_wdata_s),
    .wmask_i (cur_ben_s),
    .rdata_o (rdata_s)
  );

  assign bus.o_MEM_mem_DmemDataR = rdata_s;
  assign bus.o_MEM_mem_Stall     = stall_s;
  assign bus.o_MEM_mem_Fault     = fault_q;

endmodule
